// File: rtl/whack_round_ctrl_if.sv
// Board-side bundle for the whack-a-mole round sequencer: start pulse and
// switches in, mole LEDs and game status out.
interface whack_round_ctrl_if;
    logic        start;
    logic [15:0] sw;
    logic [15:0] LED;
    logic [5:0]  score_count;
    logic [3:0]  miss_count;
    logic        game_over;

    // Driver side: supplies start/switches, observes the game status.
    modport master (
        output start,
        output sw,
        input  LED,
        input  score_count,
        input  miss_count,
        input  game_over
    );

    // Sequencer side.
    modport slave (
        input  start,
        input  sw,
        output LED,
        output score_count,
        output miss_count,
        output game_over
    );
endinterface

// File: rtl/whack_round_ctrl.sv
// Whack-a-mole round sequencer: picks a pseudo-random mole from an LFSR,
// lights it, times the player's response, scores hits/misses and ends the
// game on a score or miss limit. All outputs are registered.
module whack_round_ctrl #(
    parameter int          MOLE_TIMEOUT = 50000000,
    parameter int          MAX_MISSES   = 3,
    parameter int          MAX_SCORE    = 32,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic clk,
    input  logic reset,
    whack_round_ctrl_if.slave bus
);

    localparam int TIMER_W = (MOLE_TIMEOUT > 1) ? $clog2(MOLE_TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(MOLE_TIMEOUT - 1);
    // Compare the pre-increment count against limit-1 so the terminal
    // decision is made in the same cycle the counter steps.
    localparam logic [5:0] SCORE_LAST = 6'(MAX_SCORE - 1);
    localparam logic [3:0] MISS_LAST  = 4'(MAX_MISSES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SPAWN,
        WAIT,
        HIT,
        MISS,
        OVER
    } state_t;

    state_t              state_reg;
    logic [15:0]         lfsr_reg;
    logic [15:0]         sw_q_reg;
    logic [3:0]          mole_idx_reg;
    logic [TIMER_W-1:0]  timer_reg;
    logic [15:0]         led_reg;
    logic [5:0]          score_reg;
    logic [3:0]          miss_reg;
    logic                game_over_reg;

    logic                lfsr_fb;
    logic [15:0]         toggle;
    logic [3:0]          cand_raw;
    logic [3:0]          cand;

    assign lfsr_fb  = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
    assign toggle   = bus.sw ^ sw_q_reg;
    assign cand_raw = lfsr_reg[3:0];
    // Bump a repeated candidate by one so a mole never lights twice in a row.
    assign cand     = (cand_raw == mole_idx_reg) ? cand_raw + 4'd1 : cand_raw;

    // Free-running Fibonacci LFSR (taps 16,14,13,11).
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};
        end
    end

    // Previous switch image, tracked in every state and during reset.
    always_ff @(posedge clk) begin
        sw_q_reg <= bus.sw;
    end

    // Round FSM; LED/game_over are decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            mole_idx_reg  <= 4'd0;
            timer_reg     <= '0;
            led_reg       <= 16'h0000;
            score_reg     <= 6'd0;
            miss_reg      <= 4'd0;
            game_over_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    led_reg       <= 16'h0000;
                    game_over_reg <= 1'b0;
                    if (bus.start) begin
                        state_reg <= SPAWN;
                        score_reg <= 6'd0;
                        miss_reg  <= 4'd0;
                    end
                end
                SPAWN: begin
                    mole_idx_reg <= cand;
                    timer_reg    <= '0;
                    led_reg      <= 16'd1 << cand;
                    state_reg    <= WAIT;
                end
                WAIT: begin
                    timer_reg <= timer_reg + 1'b1;
                    if (toggle[mole_idx_reg]) begin
                        state_reg <= HIT;
                        led_reg   <= 16'h0000;
                    end else if ((|toggle) || (timer_reg == TIMER_LAST)) begin
                        state_reg <= MISS;
                        led_reg   <= 16'h0000;
                    end
                end
                HIT: begin
                    score_reg <= score_reg + 6'd1;
                    if (score_reg == SCORE_LAST) begin
                        state_reg     <= OVER;
                        led_reg       <= 16'hFFFF;
                        game_over_reg <= 1'b1;
                    end else begin
                        state_reg <= SPAWN;
                        led_reg   <= 16'h0000;
                    end
                end
                MISS: begin
                    miss_reg <= miss_reg + 4'd1;
                    if (miss_reg == MISS_LAST) begin
                        state_reg     <= OVER;
                        led_reg       <= 16'hFFFF;
                        game_over_reg <= 1'b1;
                    end else begin
                        state_reg <= SPAWN;
                        led_reg   <= 16'h0000;
                    end
                end
                OVER: begin
                    if (bus.start) begin
                        state_reg     <= SPAWN;
                        score_reg     <= 6'd0;
                        miss_reg      <= 4'd0;
                        led_reg       <= 16'h0000;
                        game_over_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    led_reg   <= 16'h0000;
                end
            endcase
        end
    end

    assign bus.LED         = led_reg;
    assign bus.score_count = score_reg;
    assign bus.miss_count  = miss_reg;
    assign bus.game_over   = game_over_reg;

endmodule

// File: tb/tb_whack_round_ctrl.sv
// Directed bench for whack_round_ctrl with a short timeout and small limits.
module tb_whack_round_ctrl;

    logic clk;
    logic reset;
    int   pass_cnt;
    int   total_cnt;

    whack_round_ctrl_if bus();

    whack_round_ctrl #(
        .MOLE_TIMEOUT (8),
        .MAX_MISSES   (3),
        .MAX_SCORE    (4),
        .LFSR_SEED    (16'hACE1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs === exp) begin
            pass_cnt++;
            $display("check %s ok: %0h", tag, obs);
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    // Wait (bounded) for a single mole LED and return its index.
    task automatic wait_led(output int idx);
        int n;
        n = 0;
        while ((bus.LED == 16'h0000 || bus.LED == 16'hFFFF) && n < 30) begin
            step();
            n++;
        end
        idx = 0;
        if (bus.LED == 16'h0000 || bus.LED == 16'hFFFF) begin
            check("led_wait_timeout", 32'd0, 32'd1);
        end else begin
            for (int b = 0; b < 16; b++) begin
                if (bus.LED[b]) idx = b;
            end
        end
    endtask

    // Hit the currently lit mole and let the HIT cycle complete.
    task automatic do_hit(output int idx);
        wait_led(idx);
        bus.sw[idx] = ~bus.sw[idx];
        step();
        step();
    endtask

    initial begin
        int idx;
        int idx2;
        int prev;
        int lit;
        int lit_seen;
        int repeats;
        int wrong;

        pass_cnt  = 0;
        total_cnt = 0;
        bus.start = 1'b0;
        bus.sw    = 16'h0000;
        reset     = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();

        // Reset state and idle quiet period.
        check("rst_led", bus.LED, 32'h0);
        check("rst_score", bus.score_count, 32'd0);
        check("rst_miss", bus.miss_count, 32'd0);
        check("rst_game_over", bus.game_over, 32'd0);
        lit_seen = 0;
        for (int i = 0; i < 20; i++) begin
            bus.sw = bus.sw ^ 16'h0101;
            step();
            if (bus.LED != 16'h0000 || bus.score_count != 6'd0 || bus.miss_count != 4'd0) lit_seen++;
        end
        check("idle_quiet", lit_seen, 32'd0);

        // Hit: toggle the mole switch 3 cycles after it lights.
        pulse_start();
        wait_led(idx);
        check("hit_onehot", $countones(bus.LED), 32'd1);
        step();
        step();
        step();
        check("hit_led_hold", bus.LED, 32'd1 << idx);
        bus.sw[idx] = ~bus.sw[idx];
        step();
        check("hit_lat1_score", bus.score_count, 32'd0);
        check("hit_lat1_led", bus.LED, 32'h0);
        step();
        check("hit_score", bus.score_count, 32'd1);
        check("hit_led_off", bus.LED, 32'h0);
        step();
        wait_led(idx2);
        check("hit_new_onehot", $countones(bus.LED), 32'd1);
        check("hit_new_idx_differs", (idx2 != idx), 32'd1);

        // Timeouts: each mole stays lit 8 cycles, miss counted on the edge after.
        reset = 1'b1;
        step();
        reset = 1'b0;
        pulse_start();
        for (int k = 1; k <= 3; k++) begin
            wait_led(idx);
            lit = 1;
            while (bus.LED != 16'h0000 && lit < 20) begin
                step();
                if (bus.LED != 16'h0000) lit++;
            end
            check($sformatf("to%0d_lit_cycles", k), lit, 32'd8);
            check($sformatf("to%0d_miss_pending", k), bus.miss_count, k - 1);
            step();
            check($sformatf("to%0d_miss", k), bus.miss_count, k);
        end
        check("to_game_over", bus.game_over, 32'd1);
        check("to_led_all", bus.LED, 32'hFFFF);
        check("to_score", bus.score_count, 32'd0);

        // Wrong switch gives a miss; mole plus wrong switch together gives a hit.
        pulse_start();
        check("restart_miss_clr", bus.miss_count, 32'd0);
        check("restart_game_over", bus.game_over, 32'd0);
        wait_led(idx);
        wrong = idx ^ 1;
        bus.sw[wrong] = ~bus.sw[wrong];
        step();
        step();
        check("wrong_miss", bus.miss_count, 32'd1);
        check("wrong_score", bus.score_count, 32'd0);
        wait_led(idx2);
        bus.sw[idx2]     = ~bus.sw[idx2];
        bus.sw[idx2 ^ 1] = ~bus.sw[idx2 ^ 1];
        step();
        step();
        check("both_score", bus.score_count, 32'd1);
        check("both_miss", bus.miss_count, 32'd1);

        // Four consecutive hits end the game; restart clears it.
        reset = 1'b1;
        step();
        reset = 1'b0;
        pulse_start();
        for (int h = 0; h < 4; h++) do_hit(idx);
        check("max_score", bus.score_count, 32'd4);
        check("max_game_over", bus.game_over, 32'd1);
        check("max_led_all", bus.LED, 32'hFFFF);
        pulse_start();
        check("over_start_score", bus.score_count, 32'd0);
        check("over_start_miss", bus.miss_count, 32'd0);
        check("over_start_game_over", bus.game_over, 32'd0);
        check("over_start_led_off", bus.LED, 32'h0);
        step();
        check("over_start_mole", $countones(bus.LED), 32'd1);

        // Reset in WAIT with score 2.
        do_hit(idx);
        do_hit(idx);
        wait_led(idx);
        check("pre_reset_score", bus.score_count, 32'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_led", bus.LED, 32'h0);
        check("midrst_score", bus.score_count, 32'd0);
        step();
        check("midrst_idle", bus.LED, 32'h0);

        // 64 spawns: no mole index repeats back-to-back.
        pulse_start();
        prev    = -1;
        repeats = 0;
        for (int s = 0; s < 64; s++) begin
            do_hit(idx);
            if (idx == prev) repeats++;
            prev = idx;
            if (bus.game_over) pulse_start();
        end
        check("no_repeat", repeats, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
